seq_alu: RTL

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/alu_pkg.sv | 30 +++
 rtl/seq_alu_mul.sv | 67 ++++++
 rtl/seq_alu.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op encodings, FSM state type
// and the registered flag bundle.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_ANDN = 4'b0100;
  localparam logic [3:0] OP_ORN  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic ovf;
  } flags_t;

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative shift-add multiplier: one partial-product step per clock,
// done/prod present the final accumulation during the last iteration cycle.
module seq_alu_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] mcand_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] acc_next_s;
  logic [WIDTH-1:0]   mplier_r;
  logic [CW-1:0]      cnt_r;
  logic               active_r;

  always_comb begin
    acc_next_s = acc_r;
    if (mplier_r[0]) begin
      acc_next_s = acc_r + mcand_r;
    end else begin
      acc_next_s = acc_r;
    end
  end

  // prod is the post-iteration accumulator so the top can capture it on the final edge
  assign done = active_r && (cnt_r == CW'(WIDTH - 1));
  assign prod = acc_next_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_r  <= '0;
      acc_r    <= '0;
      mplier_r <= '0;
      cnt_r    <= '0;
      active_r <= 1'b0;
    end else if (start) begin
      mcand_r  <= {{WIDTH{1'b0}}, a};
      acc_r    <= '0;
      mplier_r <= b;
      cnt_r    <= '0;
      active_r <= 1'b1;
    end else if (active_r) begin
      acc_r    <= acc_next_s;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      if (done) begin
        cnt_r    <= '0;
        active_r <= 1'b0;
      end else begin
        cnt_r    <= cnt_r + CW'(1);
      end
    end else begin
      acc_r <= acc_r;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/add/shift ops and an iterative multiply,
// with a valid/ready handshake on both sides and a registered result.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             busy
);

  state_t             state_r;
  state_t             state_next_s;
  logic               out_valid_r;
  logic [WIDTH-1:0]   y_r;
  flags_t             flags_r;

  logic               accept_s;
  logic               mul_start_s;
  logic               mul_done_s;
  logic [2*WIDTH-1:0] mul_prod_s;

  logic [WIDTH-1:0]   b_op_s;
  logic               cin_s;
  logic [WIDTH:0]     add_s;
  logic               add_ovf_s;
  logic [SHW-1:0]     sh_s;
  logic [WIDTH:0]     sll_s;
  logic [WIDTH:0]     srl_s;
  logic signed [WIDTH:0] sra_s;
  logic [WIDTH-1:0]   alu_y_s;
  flags_t             alu_flags_s;
  flags_t             mul_flags_s;

  assign in_ready    = (state_r == ST_IDLE) && (!out_valid_r || out_ready);
  assign accept_s    = in_valid && in_ready;
  assign mul_start_s = accept_s && (op == OP_MUL);

  assign out_valid = out_valid_r;
  assign y         = y_r;
  assign zero      = flags_r.zero;
  assign carry     = flags_r.carry;
  assign ovf       = flags_r.ovf;
  assign busy      = (state_r == ST_MUL);

  seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .reset (reset),
    .start (mul_start_s),
    .a     (a),
    .b     (b),
    .done  (mul_done_s),
    .prod  (mul_prod_s)
  );

  // op[2] turns the adder into a - b and the logic ops into their ~b forms
  assign b_op_s    = op[2] ? ~b : b;
  assign cin_s     = op[2];
  assign add_s     = {1'b0, a} + {1'b0, b_op_s} + {{WIDTH{1'b0}}, cin_s};
  assign add_ovf_s = (a[WIDTH-1] == b_op_s[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);

  // One guard bit on the shifted operand captures the last bit shifted out
  assign sh_s  = b[SHW-1:0];
  assign sll_s = {1'b0, a} << sh_s;
  assign srl_s = {a, 1'b0} >> sh_s;
  assign sra_s = $signed({a, 1'b0}) >>> sh_s;

  always_comb begin
    alu_y_s           = '0;
    alu_flags_s.carry = 1'b0;
    alu_flags_s.ovf   = 1'b0;
    case (op)
      OP_AND, OP_ANDN: alu_y_s = a & b_op_s;
      OP_OR, OP_ORN:   alu_y_s = a | b_op_s;
      OP_ADD, OP_SUB: begin
        alu_y_s           = add_s[WIDTH-1:0];
        alu_flags_s.carry = add_s[WIDTH];
        alu_flags_s.ovf   = add_ovf_s;
      end
      OP_SLTU, OP_SLT: begin
        alu_y_s           = {{(WIDTH-1){1'b0}}, add_s[WIDTH-1]};
        alu_flags_s.carry = add_s[WIDTH];
      end
      OP_SLL: begin
        alu_y_s           = sll_s[WIDTH-1:0];
        alu_flags_s.carry = sll_s[WIDTH];
      end
      OP_SRL: begin
        alu_y_s           = srl_s[WIDTH:1];
        alu_flags_s.carry = srl_s[0];
      end
      OP_SRA: begin
        alu_y_s           = sra_s[WIDTH:1];
        alu_flags_s.carry = sra_s[0];
      end
      default: alu_y_s = '0;
    endcase
    alu_flags_s.zero = (alu_y_s == '0);
  end

  always_comb begin
    mul_flags_s.zero  = (mul_prod_s[WIDTH-1:0] == '0);
    mul_flags_s.carry = 1'b0;
    mul_flags_s.ovf   = |mul_prod_s[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (mul_start_s) state_next_s = ST_MUL;
        else             state_next_s = ST_IDLE;
      end
      ST_MUL: begin
        if (mul_done_s) state_next_s = ST_HOLD;
        else            state_next_s = ST_MUL;
      end
      ST_HOLD: begin
        if (!out_valid_r || out_ready) state_next_s = ST_IDLE;
        else                           state_next_s = ST_HOLD;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // A new load wins over a same-edge consume, so back-to-back transfers never drop a result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      y_r         <= '0;
      flags_r     <= '0;
    end else if (accept_s && (op != OP_MUL)) begin
      out_valid_r <= 1'b1;
      y_r         <= alu_y_s;
      flags_r     <= alu_flags_s;
    end else if (mul_done_s) begin
      out_valid_r <= 1'b1;
      y_r         <= mul_prod_s[WIDTH-1:0];
      flags_r     <= mul_flags_s;
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

endmodule
